axi_priority_arbiter_n: RTL and testbench
=========================================

Name: axi_priority_arbiter_n

Overview:
- N-channel priority arbiter that funnels simple AXI-light-style request/response transactions from NUM_CH masters onto one slave port.
- Slave side is e.g. the memory controller's priority input.
- Generalises the fixed two-source priority input to parametrised channel count and per-channel runtime priority.
- Adds an anti-starvation aging mechanism and round-robin tie-break.
- One outstanding transaction at a time.

Parameters:
- NUM_CH, 4, number of master channels (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- PRIO_W, 2, per-channel priority width; higher value wins
- AGE_LIMIT, 15, lost arbitrations before a channel is forced to the front (>=1)
- TIMEOUT_CYCLES, 1023, cycles in ISSUE+WAIT_RSP before abort (only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- res_n  in  1  reset; one clock, reset asynchronous active-low
- m_req_valid  in  NUM_CH  per-channel request valid
- m_req_ready  out  NUM_CH  per-channel request accept (one-hot or zero)
- m_req_we  in  NUM_CH  1=write, 0=read
- m_req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
- m_req_wdata  in  NUM_CH*DATA_W  packed write data
- m_prio  in  NUM_CH*PRIO_W  packed runtime priorities
- m_rsp_valid  out  NUM_CH  one-cycle response pulse to the granted channel
- m_rsp_data  out  DATA_W  shared response data, qualified by m_rsp_valid
- s_req_valid  out  1  slave request valid
- s_req_ready  in  1  slave request accept
- s_req_we  out  1  latched we
- s_req_addr  out  ADDR_W  latched address
- s_req_wdata  out  DATA_W  latched write data
- s_rsp_valid  in  1  slave response valid; always accepted
- s_rsp_data  in  DATA_W  slave response data
- grant_id  out  $clog2(NUM_CH)  channel owning the current/last transaction
- busy  out  1  high when the FSM is not in IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync deassert via upstream res_n_syn):
  - FSM to IDLE; all outputs 0; age counters 0.
  - rr_ptr = NUM_CH-1, so channel 0 is first in round-robin order.
  - Reset mid-transaction drops the transaction silently.
- FSM IDLE -> ISSUE -> WAIT_RSP -> IDLE.
- IDLE, winner selection (combinational, only among channels with m_req_valid=1):
  - Aged class first: age==AGE_LIMIT; among aged channels, round-robin order starting at rr_ptr+1.
  - Otherwise highest m_prio; ties broken round-robin from rr_ptr+1.
- IDLE, accept:
  - m_req_ready[winner]=1 combinationally in the same cycle; all other ready bits 0. Ready is never asserted outside IDLE.
  - On accept, register we/addr/wdata/winner into grant_id, set rr_ptr=winner, go to ISSUE.
- Aging, updated only on accept cycles:
  - Granted channel cleared to 0.
  - Each other channel with m_req_valid=1 increments, saturating at AGE_LIMIT.
  - A channel with m_req_valid=0 in any IDLE cycle is cleared to 0.
- ISSUE:
  - s_req_valid=1; s_req_* stable until s_req_ready=1.
  - Handshake cycle goes to WAIT_RSP; s_req_valid drops the next cycle.
- WAIT_RSP:
  - On s_rsp_valid, register m_rsp_data=s_rsp_data and pulse m_rsp_valid[grant_id]=1 for exactly one cycle (next cycle); go to IDLE.
  - Writes also receive a response pulse (data as returned by slave).
- Latency: accept at T; s_req_valid at T+1; with s_req_ready at T+1 and s_rsp_valid at T+2, m_rsp_valid at T+3; a new accept is possible at T+3.
- s_rsp_valid outside WAIT_RSP is ignored.
- No valid requests in IDLE: no state change; counters cleared per the aging rule.
- busy = (state != IDLE). grant_id holds its value after the transaction.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - Cycle counter runs in ISSUE/WAIT_RSP, clears on entry to ISSUE.
  - On reaching TIMEOUT_CYCLES: s_req_valid=0, pulse m_rsp_valid[grant_id] with m_rsp_data=32'hDEAD_BEEF (truncated/zero-extended to DATA_W), set err_timeout=1 (sticky until reset), go to IDLE.
  - A timeout and an s_rsp_valid in the same cycle: the response wins and no error is raised.
- When undefined: no counter; err_timeout tied 0; FSM waits indefinitely.

Test Plan:
- Single read: ch2 valid, addr 0x100, slave ready immediately, rsp 0xCAFE0001 two cycles later -> m_req_ready[2] at T, m_rsp_valid=4'b0100 with data 0xCAFE0001 at T+3, grant_id=2, busy low at T+3.
- Priority: ch0 prio 1, ch3 prio 3, both valid -> ch3 granted first, ch0 second; ch0 age=1 after first accept.
- Round-robin tie: all four valid, equal prio, continuous -> grant order 0,1,2,3,0.
- Starvation: AGE_LIMIT=2, ch1 prio 0 held valid, ch0 prio 3 always re-requesting -> ch1 granted on third accept despite lower priority; age resets to 0.
- Backpressure + reset: s_req_ready low 5 cycles then res_n pulsed low in WAIT_RSP -> s_req_* stable during stall; after reset all outputs 0, grant starts from ch0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> m_rsp_valid pulse with 0xDEADBEEF 8 cycles after ISSUE entry; err_timeout=1 and stays 1.

Source files
------------

// File: rtl/axi_priority_arbiter_n.sv
// axi_priority_arbiter_n
// Funnels request/response transactions from NUM_CH masters onto one slave
// port, one transaction outstanding at a time. A request is picked from the
// aged class first, then by highest runtime priority; ties in either class
// go round-robin starting after the last winner.
// Optional feature macro: ARB_TIMEOUT_EN. It adds an abort after
// TIMEOUT_CYCLES in ISSUE/WAIT_RSP and a sticky err_timeout flag.

module axi_priority_arbiter_n #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int PRIO_W         = 2,
    parameter int AGE_LIMIT      = 15,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic [NUM_CH-1:0]          m_req_valid,
    output logic [NUM_CH-1:0]          m_req_ready,
    input  logic [NUM_CH-1:0]          m_req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   m_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   m_req_wdata,
    input  logic [NUM_CH*PRIO_W-1:0]   m_prio,
    output logic [NUM_CH-1:0]          m_rsp_valid,
    output logic [DATA_W-1:0]          m_rsp_data,
    output logic                       s_req_valid,
    input  logic                       s_req_ready,
    output logic                       s_req_we,
    output logic [ADDR_W-1:0]          s_req_addr,
    output logic [DATA_W-1:0]          s_req_wdata,
    input  logic                       s_rsp_valid,
    input  logic [DATA_W-1:0]          s_rsp_data,
    output logic [$clog2(NUM_CH)-1:0]  grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

    if (NUM_CH < 2 || NUM_CH > 16 || AGE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("axi_priority_arbiter_n: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [AGE_W-1:0]    age_q [NUM_CH];
    logic [AGE_W-1:0]    age_d [NUM_CH];

    logic [PRIO_W-1:0]   prio_arr  [NUM_CH];
    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];
    logic [CH_W-1:0]     scan_idx, aged_win, prio_win, winner;
    logic [PRIO_W-1:0]   prio_best;
    logic                aged_found, prio_found, accept;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Unpack the flat per-channel buses into arrays indexed by channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            prio_arr[i]  = m_prio[i*PRIO_W +: PRIO_W];
            addr_arr[i]  = m_req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = m_req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Winner selection: first aged channel in round-robin order, else the first
    // channel holding the highest priority in round-robin order.
    always_comb begin
        // NOTE: every variable this block writes gets a default first, so no latch is inferred.
        aged_found = 1'b0;
        aged_win   = '0;
        prio_found = 1'b0;
        prio_best  = '0;
        prio_win   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (m_req_valid[scan_idx]) begin
                if (!aged_found && age_q[scan_idx] == AGE_MAX) begin
                    aged_found = 1'b1;
                    aged_win   = scan_idx;
                end
                if (!prio_found || prio_arr[scan_idx] > prio_best) begin
                    prio_found = 1'b1;
                    prio_best  = prio_arr[scan_idx];
                    prio_win   = scan_idx;
                end
            end
        end
        winner = aged_found ? aged_win : prio_win;
    end

    assign accept = (state_q == IDLE) && (|m_req_valid);

    // Next-state, ready, latch-on-accept, aging and response logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        m_req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            age_d[i] = age_q[i];
        end
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q;
        err_d = err_q;
`endif

        case (state_q)
            IDLE: begin
                // Every valid channel in IDLE is part of an accept cycle.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!m_req_valid[i] || CH_W'(i) == winner) begin
                        age_d[i] = '0;
                    end else if (age_q[i] != AGE_MAX) begin
                        age_d[i] = age_q[i] + AGE_W'(1);
                    end
                end
                if (accept) begin
                    m_req_ready[winner] = 1'b1;
                    we_d     = m_req_we[winner];
                    addr_d   = addr_arr[winner];
                    wdata_d  = wdata_arr[winner];
                    grant_d  = winner;
                    rr_ptr_d = winner;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (s_req_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (s_rsp_valid) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_data_d           = s_rsp_data;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ARB_TIMEOUT_EN
        // A response arriving in the timeout cycle wins over the abort.
        if (accept) begin
            cnt_d = '0;
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !(state_q == WAIT_RSP && s_rsp_valid)) begin
                state_d              = IDLE;
                rsp_valid_d          = '0;
                rsp_valid_d[grant_q] = 1'b1;
                rsp_data_d           = TIMEOUT_DATA;
                err_d                = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            grant_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            // NOTE: age counters are a handful of flops, not a RAM, so they take the reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                age_q[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            cnt_q <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state takes non-blocking assignments; the combinational blocks above use blocking.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int i = 0; i < NUM_CH; i++) begin
                age_q[i] <= age_d[i];
            end
`ifdef ARB_TIMEOUT_EN
            cnt_q <= cnt_d;
            err_q <= err_d;
`endif
        end
    end

    assign s_req_valid = (state_q == ISSUE);
    assign s_req_we    = we_q;
    assign s_req_addr  = addr_q;
    assign s_req_wdata = wdata_q;
    assign m_rsp_valid = rsp_valid_q;
    assign m_rsp_data  = rsp_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_priority_arbiter_n.sv
// Testbench for axi_priority_arbiter_n (AGE_LIMIT=2, TIMEOUT_CYCLES=8).
// Grants and responses are pushed to scoreboards when stimulus is issued; a
// monitor pops and compares whenever the DUT presents ready or a response.
// The timeout scenario runs only when ARB_TIMEOUT_EN is defined.

module tb_axi_priority_arbiter_n;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PRIO_W = 2;

    logic                      clk;
    logic                      res_n;
    logic [NUM_CH-1:0]         m_req_valid;
    logic [NUM_CH-1:0]         m_req_ready;
    logic [NUM_CH-1:0]         m_req_we;
    logic [NUM_CH*ADDR_W-1:0]  m_req_addr;
    logic [NUM_CH*DATA_W-1:0]  m_req_wdata;
    logic [NUM_CH*PRIO_W-1:0]  m_prio;
    logic [NUM_CH-1:0]         m_rsp_valid;
    logic [DATA_W-1:0]         m_rsp_data;
    logic                      s_req_valid;
    logic                      s_req_ready;
    logic                      s_req_we;
    logic [ADDR_W-1:0]         s_req_addr;
    logic [DATA_W-1:0]         s_req_wdata;
    logic                      s_rsp_valid;
    logic [DATA_W-1:0]         s_rsp_data;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      err_timeout;

    axi_priority_arbiter_n #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_W(PRIO_W),
        .AGE_LIMIT(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .res_n(res_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_prio(m_prio),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
        .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] onehot;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [NUM_CH-1:0] exp_grant_q [$];
    rsp_t              exp_rsp_q [$];
    int checks = 0;
    int errors = 0;

    // Master-side stimulus: main thread raises req_total, driver owns issued.
    int          req_total [NUM_CH];
    int          issued    [NUM_CH];
    logic [31:0] ch_addr   [NUM_CH];
    logic [31:0] ch_wdata  [NUM_CH];
    logic        ch_we     [NUM_CH];
    logic [1:0]  ch_prio   [NUM_CH];

    // Slave model controls.
    int   slave_stall;
    bit   slave_respond_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int ch, input logic [31:0] data);
        rsp_t r;
        r.onehot = NUM_CH'(1 << ch);
        r.data   = data;
        exp_grant_q.push_back(NUM_CH'(1 << ch));
        exp_rsp_q.push_back(r);
    endtask

    task automatic drive_masters();
        for (int i = 0; i < NUM_CH; i++) begin
            m_req_valid[i]                   = (issued[i] < req_total[i]);
            m_req_we[i]                      = ch_we[i];
            m_req_addr[i*ADDR_W +: ADDR_W]   = ch_addr[i];
            m_req_wdata[i*DATA_W +: DATA_W]  = ch_wdata[i];
            m_prio[i*PRIO_W +: PRIO_W]       = ch_prio[i];
        end
    endtask

    // Master driver: a channel keeps requesting until its accepts reach req_total.
    initial begin
        logic [NUM_CH-1:0] acc;
        for (int i = 0; i < NUM_CH; i++) issued[i] = 0;
        drive_masters();
        forever begin
            @(negedge clk);
            acc = m_req_ready & m_req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i] && res_n) issued[i]++;
            end
            drive_masters();
        end
    end

    // Slave model: ready after slave_stall cycles, response one cycle after the
    // handshake with data 0xCAFE0000 | (addr >> 8).
    initial begin
        int          stall_left;
        logic [31:0] addr_seen;
        stall_left  = 0;
        addr_seen   = '0;
        s_req_ready = 1'b0;
        s_rsp_valid = 1'b0;
        s_rsp_data  = '0;
        forever begin
            @(negedge clk);
            s_rsp_valid = 1'b0;
            if (!res_n) begin
                s_req_ready = 1'b0;
                stall_left  = slave_stall;
            end else if (s_req_ready) begin
                s_req_ready = 1'b0;
                if (slave_respond_en) begin
                    s_rsp_valid = 1'b1;
                    s_rsp_data  = 32'hCAFE_0000 | (addr_seen >> 8);
                end
            end else if (s_req_valid) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    s_req_ready = 1'b1;
                    addr_seen   = s_req_addr;
                end
            end else begin
                stall_left = slave_stall;
            end
        end
    end

    // Monitor: every ready and every response pulse is matched against the scoreboards.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (res_n) begin
                if (m_req_ready != '0) begin
                    if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(m_req_ready), 64'd0);
                    else check("grant", 64'(m_req_ready), 64'(exp_grant_q.pop_front()));
                end
                if (m_rsp_valid != '0) begin
                    if (exp_rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(m_rsp_valid), 64'd0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_valid", 64'(m_rsp_valid), 64'(r.onehot));
                        check("rsp_data", 64'(m_rsp_data), 64'(r.data));
                    end
                end
            end
        end
    end

    function automatic bit masters_pending();
        for (int i = 0; i < NUM_CH; i++) begin
            if (issued[i] < req_total[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_grant_q.size() != 0 || exp_rsp_q.size() != 0 || busy || masters_pending()) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 300), 64'd1);
        for (int i = 0; i < NUM_CH; i++) ch_prio[i] = 2'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grant(input int ch, input string name);
        logic [NUM_CH-1:0] mask;
        int n = 0;
        mask = NUM_CH'(1 << ch);
        @(negedge clk);
        while ((m_req_ready & mask) == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(m_req_ready & mask), 64'(mask));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req_ready"}, 64'(m_req_ready), 64'd0);
        check({tag, "_m_rsp_valid"}, 64'(m_rsp_valid), 64'd0);
        check({tag, "_m_rsp_data"},  64'(m_rsp_data),  64'd0);
        check({tag, "_s_req_valid"}, 64'(s_req_valid), 64'd0);
        check({tag, "_s_req_we"},    64'(s_req_we),    64'd0);
        check({tag, "_s_req_addr"},  64'(s_req_addr),  64'd0);
        check({tag, "_s_req_wdata"}, 64'(s_req_wdata), 64'd0);
        check({tag, "_grant_id"},    64'(grant_id),    64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_n            = 1'b0;
        slave_stall      = 0;
        slave_respond_en = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            req_total[i] = 0;
            ch_addr[i]   = '0;
            ch_wdata[i]  = '0;
            ch_we[i]     = 1'b0;
            ch_prio[i]   = 2'd0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        res_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin tie, equal priority, continuous: 0,1,2,3,0.
        for (int i = 0; i < NUM_CH; i++) ch_addr[i] = 32'((i + 1) << 8);
        expect_txn(0, 32'hCAFE_0001);
        expect_txn(1, 32'hCAFE_0002);
        expect_txn(2, 32'hCAFE_0003);
        expect_txn(3, 32'hCAFE_0004);
        expect_txn(0, 32'hCAFE_0001);
        req_total[0] += 2;
        req_total[1] += 1;
        req_total[2] += 1;
        req_total[3] += 1;
        wait_done("rr_done");

        // Single read on ch2 with cycle-exact latency.
        ch_addr[2] = 32'h0000_0100;
        expect_txn(2, 32'hCAFE_0001);
        req_total[2] += 1;
        wait_grant(2, "single_ready_T");
        @(negedge clk);
        check("single_s_req_valid_T1", 64'(s_req_valid), 64'd1);
        check("single_busy_T1", 64'(busy), 64'd1);
        @(negedge clk);
        check("single_s_req_valid_T2", 64'(s_req_valid), 64'd0);
        @(negedge clk);
        check("single_rsp_valid_T3", 64'(m_rsp_valid), 64'b0100);
        check("single_rsp_data_T3", 64'(m_rsp_data), 64'hCAFE_0001);
        check("single_busy_T3", 64'(busy), 64'd0);
        check("single_grant_id_T3", 64'(grant_id), 64'd2);
        @(negedge clk);
        check("single_rsp_pulse_T4", 64'(m_rsp_valid), 64'd0);
        check("single_grant_hold_T4", 64'(grant_id), 64'd2);
        wait_done("single_done");

        // Priority: ch3 (prio 3) before ch0 (prio 1).
        ch_addr[0] = 32'h0000_0200;
        ch_addr[3] = 32'h0000_0300;
        ch_prio[0] = 2'd1;
        ch_prio[3] = 2'd3;
        expect_txn(3, 32'hCAFE_0003);
        expect_txn(0, 32'hCAFE_0002);
        req_total[0] += 1;
        req_total[3] += 1;
        wait_done("prio_done");

        // Starvation: ch1 prio 0 reaches age 2 after two losses to ch0 prio 3.
        ch_addr[0] = 32'h0000_0600;
        ch_addr[1] = 32'h0000_0700;
        ch_prio[0] = 2'd3;
        ch_prio[1] = 2'd0;
        expect_txn(0, 32'hCAFE_0006);
        expect_txn(0, 32'hCAFE_0006);
        expect_txn(1, 32'hCAFE_0007);
        expect_txn(0, 32'hCAFE_0006);
        req_total[0] += 3;
        req_total[1] += 1;
        wait_done("starve_done");

        // Backpressure then reset in WAIT_RSP.
        slave_stall      = 5;
        slave_respond_en = 1'b0;
        ch_addr[1]  = 32'h0000_0400;
        ch_wdata[1] = 32'h1234_5678;
        ch_we[1]    = 1'b1;
        exp_grant_q.push_back(4'b0010);
        req_total[1] += 1;
        wait_grant(1, "bp_ready_T");
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("bp_s_req_valid", 64'(s_req_valid), 64'd1);
            check("bp_s_req_addr",  64'(s_req_addr),  64'h0000_0400);
            check("bp_s_req_we",    64'(s_req_we),    64'd1);
            check("bp_s_req_wdata", 64'(s_req_wdata), 64'h1234_5678);
        end
        @(negedge clk);
        check("bp_wait_busy", 64'(busy), 64'd1);
        check("bp_wait_s_req_valid", 64'(s_req_valid), 64'd0);
        ch_we[1] = 1'b0;
        res_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        res_n            = 1'b1;
        slave_stall      = 0;
        slave_respond_en = 1'b1;
        @(negedge clk);
        check("postreset_rsp_none", 64'(m_rsp_valid), 64'd0);
        ch_addr[0] = 32'h0000_0800;
        ch_addr[2] = 32'h0000_0900;
        expect_txn(0, 32'hCAFE_0008);
        expect_txn(2, 32'hCAFE_0009);
        req_total[0] += 1;
        req_total[2] += 1;
        wait_done("postreset_done");

`ifdef ARB_TIMEOUT_EN
        // Slave never responds: abort 8 cycles after ISSUE entry.
        slave_respond_en = 1'b0;
        ch_addr[3] = 32'h0000_0A00;
        expect_txn(3, 32'hDEAD_BEEF);
        req_total[3] += 1;
        wait_grant(3, "to_ready_T");
        repeat (8) @(negedge clk);
        check("to_no_rsp_T8", 64'(m_rsp_valid), 64'd0);
        check("to_busy_T8", 64'(busy), 64'd1);
        @(negedge clk);
        check("to_rsp_valid_T9", 64'(m_rsp_valid), 64'b1000);
        check("to_rsp_data_T9", 64'(m_rsp_data), 64'hDEAD_BEEF);
        check("to_err_T9", 64'(err_timeout), 64'd1);
        check("to_busy_T9", 64'(busy), 64'd0);
        wait_done("to_done");
        slave_respond_en = 1'b1;
        ch_addr[0] = 32'h0000_0B00;
        expect_txn(0, 32'hCAFE_000B);
        req_total[0] += 1;
        wait_done("to_after_done");
        check("to_err_sticky", 64'(err_timeout), 64'd1);
`else
        check("err_timeout_tied", 64'(err_timeout), 64'd0);
`endif

        check("scoreboards_empty", 64'(exp_grant_q.size() + exp_rsp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
